// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcode encodings and branch-resolve FSM states.
// Also holds the sizing of the squash down-counter, which must fit the largest SQUASH_CYC of 7.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BRZ  = 3'b001,
        BR_BRN  = 3'b010,
        BR_J    = 3'b011,
        BR_JR   = 3'b100
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } br_state_e;

    localparam int SQ_W = 3;

    // Reserved opcodes 101..111 behave as NONE and are not counted as branches.
    function automatic logic is_branch(input logic [2:0] op);
        return (op == BR_BRZ) || (op == BR_BRN) || (op == BR_J) || (op == BR_JR);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational taken evaluation for a branch against the architectural flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] br_op,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       taken
);

    always_comb begin
        // NOTE: default assignment first so every path drives taken and no latch is inferred.
        taken = 1'b0;
        case (br_op)
            BR_BRZ:  taken = flag_z;
            BR_BRN:  taken = flag_n;
            BR_J:    taken = 1'b1;
            BR_JR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: flag register, redirect/flush sequencing FSM and
// saturating branch/taken counters. All outputs come straight from registers.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int SQUASH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_setflags,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic [2:0]       br_op,
    input  logic [XLEN-1:0]  pc_target,
    input  logic [XLEN-1:0]  rs_val,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             flag_z,
    output logic             flag_n,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYC - 1);

    br_state_e        r_state;
    logic [SQ_W-1:0]  r_sq_cnt;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_flush;
    logic             r_flag_z;
    logic             r_flag_n;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             w_taken;

    // Conditions read the registered flags, so a setflags+branch instruction sees the old values.
    branch_cond u_branch_cond (
        .br_op  (br_op),
        .flag_z (r_flag_z),
        .flag_n (r_flag_n),
        .taken  (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_sq_cnt         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_flag_z         <= 1'b0;
            r_flag_n         <= 1'b0;
            r_br_cnt         <= '0;
            r_taken_cnt      <= '0;
        end else if (!ex_stall) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (ex_setflags) begin
                            r_flag_z <= alu_z;
                            r_flag_n <= alu_n;
                        end
                        if (is_branch(br_op) && (r_br_cnt != '1))
                            r_br_cnt <= r_br_cnt + CNT_W'(1);
                        if (w_taken) begin
                            if (r_taken_cnt != '1)
                                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                            r_redirect_pc    <= (br_op == BR_JR) ? rs_val : pc_target;
                            r_redirect_valid <= 1'b1;
                            r_flush          <= 1'b1;
                            r_state          <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    r_redirect_valid <= 1'b0;
                    if (SQUASH_CYC == 1) begin
                        r_flush <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_sq_cnt <= SQ_LOAD;
                        r_state  <= ST_SQUASH;
                    end
                end
                ST_SQUASH: begin
                    if (r_sq_cnt <= SQ_W'(1)) begin
                        r_sq_cnt <= '0;
                        r_flush  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_sq_cnt <= r_sq_cnt - SQ_W'(1);
                    end
                end
                default: begin
                    r_redirect_valid <= 1'b0;
                    r_flush          <= 1'b0;
                    r_state          <= ST_IDLE;
                end
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign flag_z         = r_flag_z;
    assign flag_n         = r_flag_n;
    assign br_cnt         = r_br_cnt;
    assign taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: expected redirects go into a scoreboard queue that a
// negedge monitor drains; counters, flags and flush are checked inline after each step.
module tb_branch_resolve;
    import cpu_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid, ex_stall, ex_setflags, alu_z, alu_n;
    logic [2:0]       br_op;
    logic [XLEN-1:0]  pc_target, rs_val;

    logic             redirect_valid, flush, flag_z, flag_n;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_cnt, taken_cnt;

    logic             s1_redirect_valid, s1_flush, s1_flag_z, s1_flag_n;
    logic [XLEN-1:0]  s1_redirect_pc;
    logic [CNT_W-1:0] s1_br_cnt, s1_taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];
    logic prev_rv = 1'b0;

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W), .SQUASH_CYC(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_setflags(ex_setflags), .alu_z(alu_z), .alu_n(alu_n), .br_op(br_op),
        .pc_target(pc_target), .rs_val(rs_val), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .flag_z(flag_z), .flag_n(flag_n),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W), .SQUASH_CYC(1)) dut_sq1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_setflags(ex_setflags), .alu_z(alu_z), .alu_n(alu_n), .br_op(br_op),
        .pc_target(pc_target), .rs_val(rs_val), .redirect_valid(s1_redirect_valid),
        .redirect_pc(s1_redirect_pc), .flush(s1_flush), .flag_z(s1_flag_z), .flag_n(s1_flag_n),
        .br_cnt(s1_br_cnt), .taken_cnt(s1_taken_cnt)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: each new redirect pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (redirect_valid && !prev_rv) begin
            if (exp_q.size() == 0)
                check("unexpected_redirect", 32'd1, 32'd0);
            else
                check("redirect_pc_sb", redirect_pc, exp_q.pop_front());
        end
        prev_rv <= redirect_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_setflags = 1'b0;
        alu_z = 1'b0; alu_n = 1'b0; br_op = BR_NONE;
        pc_target = '0; rs_val = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Present one valid instruction for one edge; the expected redirect is queued first.
    task automatic issue(input logic setf, input logic z, input logic n, input logic [2:0] op,
                         input logic [31:0] tgt, input logic [31:0] rs,
                         input logic exp_redir, input logic [31:0] exp_pc);
        ex_valid = 1'b1; ex_setflags = setf; alu_z = z; alu_n = n;
        br_op = op; pc_target = tgt; rs_val = rs;
        if (exp_redir) exp_q.push_back(exp_pc);
        cyc();
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_flush",          {31'd0, flush},          32'd0);
        check("rst_redirect_pc",    redirect_pc,             32'd0);
        check("rst_flags",          {30'd0, flag_z, flag_n}, 32'd0);
        check("rst_counters",       {24'd0, br_cnt, taken_cnt}, 32'd0);
        cyc();
        rst = 1'b0;

        // setflags z=1, then BRZ to 0x40: one-cycle redirect, two flush cycles.
        issue(1'b1, 1'b1, 1'b0, BR_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        check("s1_flag_z", {31'd0, flag_z}, 32'd1);
        check("s1_br_cnt_none", {28'd0, br_cnt}, 32'd0);
        issue(1'b0, 1'b0, 1'b0, BR_BRZ, 32'h40, 32'h9, 1'b1, 32'h40);
        check("s1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("s1_redirect_pc", redirect_pc, 32'h40);
        check("s1_flush_c1", {31'd0, flush}, 32'd1);
        check("s1_sq1_flush_c1", {31'd0, s1_flush}, 32'd1);
        cyc();
        check("s1_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
        check("s1_flush_c2", {31'd0, flush}, 32'd1);
        check("s1_sq1_flush_c2", {31'd0, s1_flush}, 32'd0);
        cyc();
        check("s1_flush_c3", {31'd0, flush}, 32'd0);
        check("s1_br_cnt", {28'd0, br_cnt}, 32'd1);
        check("s1_taken_cnt", {28'd0, taken_cnt}, 32'd1);

        // setflags n=0, BRN not taken; a reserved opcode is not counted.
        do_reset();
        issue(1'b1, 1'b0, 1'b0, BR_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 1'b0, BR_BRN, 32'h80, 32'h0, 1'b0, 32'h0);
        check("s2_no_redirect", {31'd0, redirect_valid}, 32'd0);
        check("s2_no_flush", {31'd0, flush}, 32'd0);
        issue(1'b0, 1'b0, 1'b0, 3'b111, 32'h84, 32'h0, 1'b0, 32'h0);
        check("s2_br_cnt", {28'd0, br_cnt}, 32'd1);
        check("s2_taken_cnt", {28'd0, taken_cnt}, 32'd0);

        // Same-instruction setflags+BRZ sees the old flag_z=0 yet updates the flags.
        issue(1'b1, 1'b1, 1'b1, BR_BRZ, 32'h90, 32'h0, 1'b0, 32'h0);
        check("s2b_no_redirect", {31'd0, redirect_valid}, 32'd0);
        check("s2b_flags", {30'd0, flag_z, flag_n}, 32'd3);
        check("s2b_br_cnt", {28'd0, br_cnt}, 32'd2);

        // JR to 0x1234, wrong-path setflags+J during SQUASH is ignored.
        do_reset();
        issue(1'b0, 1'b0, 1'b0, BR_JR, 32'h99, 32'h1234, 1'b1, 32'h1234);
        check("s3_redirect_pc", redirect_pc, 32'h1234);
        cyc();
        ex_valid = 1'b1; ex_setflags = 1'b1; alu_z = 1'b1; br_op = BR_J; pc_target = 32'h77;
        cyc();
        clear_inputs();
        check("s3_flag_z", {31'd0, flag_z}, 32'd0);
        check("s3_br_cnt", {28'd0, br_cnt}, 32'd1);
        check("s3_taken_cnt", {28'd0, taken_cnt}, 32'd1);
        check("s3_flush_done", {31'd0, flush}, 32'd0);

        // A stalled J is not accepted; then J with a 3-cycle stall in REDIRECT.
        do_reset();
        ex_stall = 1'b1;
        issue(1'b0, 1'b0, 1'b0, BR_J, 32'h100, 32'h0, 1'b0, 32'h0);
        check("s4_stall_idle_rv", {31'd0, redirect_valid}, 32'd0);
        check("s4_stall_idle_cnt", {28'd0, br_cnt}, 32'd0);
        issue(1'b0, 1'b0, 1'b0, BR_J, 32'h200, 32'h0, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            ex_stall = 1'b1;
            cyc();
            check("s4_stall_rv", {31'd0, redirect_valid}, 32'd1);
            check("s4_stall_flush", {31'd0, flush}, 32'd1);
        end
        ex_stall = 1'b0;
        cyc();
        check("s4_squash_rv", {31'd0, redirect_valid}, 32'd0);
        check("s4_squash_flush", {31'd0, flush}, 32'd1);
        cyc();
        check("s4_end_flush", {31'd0, flush}, 32'd0);
        check("s4_taken_cnt", {28'd0, taken_cnt}, 32'd1);

        // Reset mid-SQUASH clears everything at once; BRZ afterwards is not taken.
        do_reset();
        issue(1'b0, 1'b0, 1'b0, BR_J, 32'h300, 32'h0, 1'b1, 32'h300);
        cyc();
        check("s5_in_squash", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        #2;
        check("s5_rst_flush", {31'd0, flush}, 32'd0);
        check("s5_rst_redirect_pc", redirect_pc, 32'd0);
        check("s5_rst_counters", {24'd0, br_cnt, taken_cnt}, 32'd0);
        cyc();
        rst = 1'b0;
        issue(1'b0, 1'b0, 1'b0, BR_BRZ, 32'h50, 32'h0, 1'b0, 32'h0);
        check("s5_brz_no_redirect", {31'd0, redirect_valid}, 32'd0);
        check("s5_brz_no_flush", {31'd0, flush}, 32'd0);
        check("s5_br_cnt", {28'd0, br_cnt}, 32'd1);
        check("s5_taken_cnt", {28'd0, taken_cnt}, 32'd0);

        // 20 taken J branches saturate the 4-bit counters at 15.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(1'b0, 1'b0, 1'b0, BR_J, 32'h1000 + 32'(i * 4), 32'h0, 1'b1, 32'h1000 + 32'(i * 4));
            cyc();
            cyc();
            if (i == 14) check("s6_br_cnt_at15", {28'd0, br_cnt}, 32'd15);
        end
        check("s6_br_cnt_sat", {28'd0, br_cnt}, 32'd15);
        check("s6_taken_cnt_sat", {28'd0, taken_cnt}, 32'd15);

        cyc();
        cyc();
        check("pending_redirects", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter XLEN, default 32: width of PC, target and register operands.
REQ-002 Parameter CNT_W, default 16: width of the saturating performance counters.
REQ-003 Parameter SQUASH_CYC, default 2: number of cycles `flush` stays asserted after a taken branch; legal range 1..7.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ex_valid  input  1  the EX-stage instruction is valid.
REQ-007 ex_stall  input  1  the pipeline is frozen this cycle.
REQ-008 ex_setflags  input  1  the EX instruction writes the Z/N flags.
REQ-009 alu_z  input  1  ALU zero flag for the EX instruction.
REQ-010 alu_n  input  1  ALU negative flag for the EX instruction.
REQ-011 br_op  input  3  branch type: 000 NONE, 001 BRZ, 010 BRN, 011 J (PC-relative), 100 JR (register); all other codes are treated as NONE.
REQ-012 pc_target  input  XLEN  PC+imm target.
REQ-013 rs_val  input  XLEN  register target for JR.
REQ-014 redirect_valid  output  1  fetch shall load redirect_pc.
REQ-015 redirect_pc  output  XLEN  redirect address.
REQ-016 flush  output  1  squash the IF/ID/EX wrong-path instructions.
REQ-017 flag_z, flag_n  output  1 each  architectural flag register.
REQ-018 br_cnt, taken_cnt  output  CNT_W each  count of resolved branches and of taken branches.

Function
REQ-019 The flag register shall load {alu_z, alu_n} when the state is IDLE and ex_valid=1, ex_stall=0 and ex_setflags=1.
REQ-020 Taken is defined per br_op: BRZ when flag_z=1; BRN when flag_n=1; J and JR always.
REQ-021 Branch conditions shall use the registered flags. When setflags and a branch occur in the same instruction, the branch shall see the old flags, and the flags shall update at the same edge.
REQ-022 The FSM shall have three states: IDLE, REDIRECT and SQUASH.
REQ-023 In IDLE, an accepted taken branch (ex_valid=1, ex_stall=0) shall move the FSM to REDIRECT at the next edge. Otherwise the FSM stays in IDLE.
REQ-024 In REDIRECT: redirect_valid=1; redirect_pc equals pc_target (BRZ/BRN/J) or rs_val (JR), captured at acceptance; flush=1. The FSM shall go to SQUASH, or straight to IDLE if SQUASH_CYC=1.
REQ-025 SQUASH shall hold flush=1 for SQUASH_CYC-1 cycles, counted by an internal down-counter, then return to IDLE.
REQ-026 Outside IDLE, ex_valid, ex_setflags and br_op shall be ignored (wrong path): no flag update, no counter update, no new redirect.
REQ-027 When ex_stall=1, the state, flag register, squash counter, redirect_pc and both counters shall hold, and all outputs keep their values.
REQ-028 Resolution latency: exactly 1 cycle from branch acceptance to redirect_valid; redirect_valid is a single-cycle pulse when no stall occurs.
REQ-029 br_cnt shall increment on every accepted br_op other than NONE. taken_cnt shall increment on every accepted taken branch.
REQ-030 Both counters shall saturate at 2^CNT_W-1 and never wrap.
REQ-031 A not-taken branch shall produce no redirect and no flush.

Reset
REQ-032 Asserting rst shall immediately set state=IDLE, flag_z=0, flag_n=0, redirect_valid=0, redirect_pc=0, flush=0, squash counter=0, br_cnt=0 and taken_cnt=0.
REQ-033 A reset during REDIRECT or SQUASH shall abort the redirect. After rst deasserts, the first accepted instruction is evaluated in IDLE.

Structure
REQ-034 The br_op encodings and the FSM state enumeration shall live in the shared package cpu_pkg.
REQ-035 The taken evaluation shall be a combinational sub-module, branch_cond, with inputs br_op, flag_z and flag_n, and output taken.
REQ-036 No other sub-modules; the target adder stays outside this block.

Verification
REQ-037 Scenario: setflags with alu_z=1, then BRZ with pc_target=0x40 -> next cycle redirect_valid=1 and redirect_pc=0x40; flush high for 2 cycles; br_cnt=1, taken_cnt=1.
REQ-038 Scenario: setflags with alu_n=0, then BRN -> no redirect and no flush; br_cnt=1, taken_cnt=0.
REQ-039 Scenario: JR with rs_val=0x1234, then a valid setflags instruction (alu_z=1) during SQUASH -> redirect_pc=0x1234; flag_z remains 0; the counters ignore the squashed instruction.
REQ-040 Scenario: J accepted, then ex_stall=1 for 3 cycles in REDIRECT -> redirect_valid and flush held for 4 cycles in total, then SQUASH for 1 cycle.
REQ-041 Scenario: rst pulsed mid-SQUASH -> flush=0 and all outputs zero immediately; a following BRZ with flag_z=0 is not taken.
REQ-042 Scenario: CNT_W=4 with 20 taken J branches -> br_cnt=taken_cnt=15 (saturated).
